// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button synchronize/debounce, run/stop/lap FSM, tick prescaler
// and display source select (live count or frozen lap snapshot).
//
// state | meaning
// IDLE  | cleared, prescaler held at 0, waiting for start
// RUN   | counting, display live
// STOP  | paused, prescaler holds its partial period
// LAP   | counting, display frozen on the snapshot
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 1000000,
    parameter int DB_CYCLES = 100000,
    parameter int PW        = 20,
    parameter int DW        = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic [3:0] cnt_ones,
    input  logic [3:0] cnt_tens,
    input  logic [3:0] cnt_hundreds,
    input  logic [3:0] cnt_thousands,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_hundreds,
    output logic [3:0] disp_thousands,
    output logic       running,
    output logic       lap_active,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;
    localparam logic [1:0] ST_LAP  = 2'd3;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

    // Bit order in all button vectors: {clr, lap, ss}
    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    db_lvl;
    logic [2:0]    db_prev;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];

    logic [1:0]    state_r;
    logic [1:0]    next_state;
    logic          clr_req;
    logic          snap_cap;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          tick_nxt;
    logic [15:0]   live;
    logic [15:0]   snap;
    logic [15:0]   disp_r;
    logic [15:0]   disp_nxt;
    logic          counting;

    assign btn_raw  = {btn_clr, btn_lap, btn_ss};
    assign press    = db_lvl & ~db_prev;
    assign live     = {cnt_thousands, cnt_hundreds, cnt_tens, cnt_ones};
    assign counting = (state_r == ST_RUN) || (state_r == ST_LAP);

    // A level is accepted only after the synced input has disagreed with it for
    // DB_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            db_lvl  <= '0;
            db_prev <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            db_prev <= db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            presc      <= '0;
            cnt_tick   <= 1'b0;
            cnt_clr    <= 1'b0;
            snap       <= '0;
            disp_r     <= '0;
        end else begin
            state_r    <= next_state;
            running    <= (next_state == ST_RUN) || (next_state == ST_LAP);
            lap_active <= (next_state == ST_LAP);
            presc      <= presc_nxt;
            cnt_tick   <= tick_nxt;
            cnt_clr    <= clr_req;
            disp_r     <= disp_nxt;
            if (snap_cap) snap <= live;
        end
    end

    // Priority clr > ss > lap, evaluated only among events meaningful in the state
    always_comb begin
        next_state = state_r;
        clr_req    = 1'b0;
        snap_cap   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (press[2])      clr_req    = 1'b1;
                else if (press[0]) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (press[0]) begin
                    next_state = ST_STOP;
                end else if (press[1]) begin
                    next_state = ST_LAP;
                    snap_cap   = 1'b1;
                end
            end
            ST_LAP: begin
                if (press[0])      next_state = ST_STOP;
                else if (press[1]) next_state = ST_RUN;
            end
            default: begin
                if (press[2]) begin
                    next_state = ST_IDLE;
                    clr_req    = 1'b1;
                end else if (press[0]) begin
                    next_state = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        presc_nxt = presc;
        if ((state_r == ST_IDLE) || clr_req) presc_nxt = '0;
        else if (counting)                   presc_nxt = (presc == TICK_LAST) ? '0 : presc + 1'b1;
        tick_nxt = counting && (presc == TICK_LAST);
        disp_nxt = live;
        if (next_state == ST_LAP) disp_nxt = snap_cap ? live : snap;
    end

    assign state          = state_r;
    assign disp_ones      = disp_r[3:0];
    assign disp_tens      = disp_r[7:4];
    assign disp_hundreds  = disp_r[11:8];
    assign disp_thousands = disp_r[15:12];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a small BCD counter model closing the loop
// between cnt_tick/cnt_clr and the live digit inputs.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_ss = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clr = 1'b0;
    logic [15:0] cnt_val;
    logic        lod_en = 1'b0;
    logic [15:0] lod_val = 16'h0;
    logic        cnt_tick;
    logic        cnt_clr;
    logic [3:0]  disp_ones;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_hundreds;
    logic [3:0]  disp_thousands;
    logic        running;
    logic        lap_active;
    logic [1:0]  state;
    logic [15:0] disp_val;

    int n_chk = 0;
    int n_err = 0;
    int nt;
    int nc;
    int nc2;
    bit seen;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV (5),
        .DB_CYCLES(3),
        .PW       (4),
        .DW       (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_ss        (btn_ss),
        .btn_lap       (btn_lap),
        .btn_clr       (btn_clr),
        .cnt_ones      (cnt_val[3:0]),
        .cnt_tens      (cnt_val[7:4]),
        .cnt_hundreds  (cnt_val[11:8]),
        .cnt_thousands (cnt_val[15:12]),
        .cnt_tick      (cnt_tick),
        .cnt_clr       (cnt_clr),
        .disp_ones     (disp_ones),
        .disp_tens     (disp_tens),
        .disp_hundreds (disp_hundreds),
        .disp_thousands(disp_thousands),
        .running       (running),
        .lap_active    (lap_active),
        .state         (state)
    );

    assign disp_val = {disp_thousands, disp_hundreds, disp_tens, disp_ones};

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit counter the controller drives; shares the board reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt_val <= 16'h0;
        else if (cnt_clr)  cnt_val <= 16'h0;
        else if (lod_en)   cnt_val <= lod_val;
        else if (cnt_tick) cnt_val <= bcd_inc(cnt_val);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic watch(input int n, output int ticks, output int clrs);
        ticks = 0;
        clrs  = 0;
        repeat (n) begin
            @(negedge clk);
            if (cnt_tick) ticks++;
            if (cnt_clr)  clrs++;
        end
    endtask

    task automatic wait_tick(output bit found);
        int i;
        found = 1'b0;
        i     = 0;
        while (!found && i < 20) begin
            @(negedge clk);
            if (cnt_tick) found = 1'b1;
            i++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        wait_n(2);
        check_val("rst_state", state, 2'd0);
        check_val("rst_running", running, 1'b0);
        check_val("rst_lap", lap_active, 1'b0);
        check_val("rst_tick", cnt_tick, 1'b0);
        check_val("rst_clr", cnt_clr, 1'b0);
        check_val("rst_disp", disp_val, 16'h0);
        rst_n = 1'b1;
        wait_n(3);

        // short glitch on ss in IDLE is rejected
        btn_ss = 1'b1;
        wait_n(2);
        btn_ss = 1'b0;
        watch(12, nt, nc);
        check_val("glitch_state", state, 2'd0);
        check_val("glitch_ticks", nt, 0);

        // clr in IDLE: one-cycle cnt_clr, stay IDLE
        btn_clr = 1'b1;
        wait_n(5);
        check_val("idle_clr_early", cnt_clr, 1'b0);
        wait_n(1);
        check_val("idle_clr_pulse", cnt_clr, 1'b1);
        check_val("idle_clr_state", state, 2'd0);
        wait_n(1);
        check_val("idle_clr_end", cnt_clr, 1'b0);
        wait_n(3);
        btn_clr = 1'b0;
        wait_n(10);

        // start: 2 sync + 3 debounce + 1 FSM cycles, then ticks every 5
        btn_ss = 1'b1;
        wait_n(5);
        check_val("start_early", state, 2'd0);
        wait_n(1);
        check_val("start_state", state, 2'd1);
        check_val("start_running", running, 1'b1);
        wait_n(4);
        check_val("tick_n10", cnt_tick, 1'b0);
        btn_ss = 1'b0;
        wait_n(1);
        check_val("tick_n11", cnt_tick, 1'b1);
        wait_n(1);
        check_val("tick_n12", cnt_tick, 1'b0);
        wait_n(4);
        check_val("tick_n16", cnt_tick, 1'b1);
        wait_n(6);

        // lap captures 0420 and freezes the display while counting goes on
        btn_lap = 1'b1;
        wait_n(4);
        lod_val = 16'h0420;
        lod_en  = 1'b1;
        wait_n(1);
        lod_en  = 1'b0;
        wait_n(1);
        check_val("lap_state", state, 2'd3);
        check_val("lap_active", lap_active, 1'b1);
        check_val("lap_running", running, 1'b1);
        check_val("lap_disp", disp_val, 16'h0420);
        wait_n(4);
        btn_lap = 1'b0;
        wait_n(10);
        check_val("lap_disp_frozen", disp_val, 16'h0420);
        btn_lap = 1'b1;
        wait_n(6);
        check_val("unlap_state", state, 2'd1);
        check_val("unlap_active", lap_active, 1'b0);
        lod_val = 16'h1234;
        lod_en  = 1'b1;
        wait_n(1);
        lod_en  = 1'b0;
        wait_n(1);
        check_val("unlap_disp_live", disp_val, 16'h1234);
        wait_n(2);
        btn_lap = 1'b0;
        wait_n(10);

        // stop with prescaler at 2; resume ticks after the remaining 3 cycles
        wait_tick(seen);
        check_val("found_tick", seen, 1'b1);
        wait_n(1);
        btn_ss = 1'b1;
        wait_n(4);
        check_val("tick_before_stop", cnt_tick, 1'b1);
        wait_n(2);
        check_val("stop_state", state, 2'd2);
        check_val("stop_running", running, 1'b0);
        wait_n(4);
        btn_ss = 1'b0;
        watch(10, nt, nc);
        check_val("stop_no_tick", nt, 0);
        btn_ss = 1'b1;
        wait_n(6);
        check_val("resume_state", state, 2'd1);
        wait_n(2);
        check_val("resume_tick_early", cnt_tick, 1'b0);
        wait_n(1);
        check_val("resume_tick", cnt_tick, 1'b1);
        wait_n(1);
        btn_ss = 1'b0;
        wait_n(4);
        check_val("resume_tick2", cnt_tick, 1'b1);
        wait_n(6);

        // stop, then clr and ss together: clr wins
        btn_ss = 1'b1;
        wait_n(6);
        check_val("stop2_state", state, 2'd2);
        wait_n(4);
        btn_ss = 1'b0;
        wait_n(10);
        btn_clr = 1'b1;
        btn_ss  = 1'b1;
        wait_n(5);
        check_val("both_early_state", state, 2'd2);
        check_val("both_early_clr", cnt_clr, 1'b0);
        wait_n(1);
        check_val("both_state", state, 2'd0);
        check_val("both_clr", cnt_clr, 1'b1);
        wait_n(1);
        check_val("both_clr_end", cnt_clr, 1'b0);
        wait_n(1);
        check_val("both_disp", disp_val, 16'h0);
        wait_n(2);
        btn_clr = 1'b0;
        btn_ss  = 1'b0;
        wait_n(10);

        // start from IDLE: prescaler restarts at 0
        btn_ss = 1'b1;
        wait_n(6);
        check_val("restart_state", state, 2'd1);
        wait_n(4);
        check_val("restart_tick_early", cnt_tick, 1'b0);
        btn_ss = 1'b0;
        wait_n(1);
        check_val("restart_tick", cnt_tick, 1'b1);
        wait_n(9);

        // clr ignored in RUN
        btn_clr = 1'b1;
        watch(10, nt, nc);
        btn_clr = 1'b0;
        watch(6, nt, nc2);
        check_val("run_clr_ignored", nc + nc2, 0);
        check_val("run_clr_state", state, 2'd1);

        // async reset in the middle of LAP
        btn_lap = 1'b1;
        wait_n(6);
        check_val("lap2_state", state, 2'd3);
        wait_n(4);
        btn_lap = 1'b0;
        wait_n(12);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_state", state, 2'd0);
        check_val("async_outs", {running, lap_active, cnt_tick, cnt_clr, disp_val}, 20'h0);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(3);
        check_val("post_rst_state", state, 2'd0);
        check_val("post_rst_disp", disp_val, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
